// File: rtl/iir_out_capture.sv
// iir_out_capture: records DEPTH enabled IIR output samples, tracks peak
// magnitude, then streams the record out over a valid/ready read port.
module iir_out_capture #(
  parameter int NB_DATA = 16,
  parameter int DEPTH   = 1024,
  parameter int NB_ADDR = 10
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_enable,
  input  logic               i_arm,
  input  logic               i_rd_ready,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic               o_rd_last,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_ADDR:0]   o_count,
  output logic [NB_DATA-1:0] o_peak
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READOUT = 2'd2
  } state_t;

  localparam logic [NB_ADDR:0] LAST_CNT =
    (NB_ADDR+1)'(DEPTH - 1);
  localparam logic [NB_ADDR:0] CNT_ONE =
    (NB_ADDR+1)'(1);
  localparam logic [NB_ADDR-1:0] PTR_ONE =
    NB_ADDR'(1);
  localparam logic [NB_DATA-1:0] MAG_MAX =
    {1'b0, {(NB_DATA-1){1'b1}}};
  localparam logic [NB_DATA-1:0] MAG_MIN =
    {1'b1, {(NB_DATA-1){1'b0}}};

  state_t state;
  state_t state_nxt;

  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR:0]   rd_cnt;
  logic [NB_DATA-1:0] ram_q;
  logic               ram_vld;
  logic               ram_last;
  logic [NB_DATA-1:0] mag;

  logic arm_go;
  logic wr_en;
  logic wr_last;
  logic rd_xfer;
  logic rd_end;
  logic out_free;
  logic rd_en;

  assign arm_go   = (state == IDLE) && i_arm;
  assign wr_en    = (state == CAPTURE) && i_enable;
  assign wr_last  = wr_en && (o_count == LAST_CNT);
  assign rd_xfer  = o_rd_valid && i_rd_ready;
  assign rd_end   = rd_xfer && o_rd_last;
  assign out_free = !o_rd_valid || i_rd_ready;
  assign rd_en    = (state == READOUT) && !rd_cnt[NB_ADDR]
                    && (!ram_vld || out_free);

  // Saturating magnitude: the most-negative code maps to max positive.
  always_comb begin
    mag = i_data;
    if (i_data == MAG_MIN) begin
      mag = MAG_MAX;
    end else if (i_data[NB_DATA-1]) begin
      mag = -i_data;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: arm, full record, last read transfer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_arm)   state_nxt = CAPTURE;
      CAPTURE: if (wr_last) state_nxt = READOUT;
      READOUT: if (rd_end)  state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    o_busy = (state != IDLE);
  end

  // Capture bookkeeping: write pointer, sample count, running peak.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      o_count <= '0;
      o_peak  <= '0;
    end else if (arm_go) begin
      wr_ptr  <= '0;
      o_count <= '0;
      o_peak  <= '0;
    end else if (wr_en) begin
      wr_ptr  <= wr_ptr + PTR_ONE;
      o_count <= o_count + CNT_ONE;
      if (mag > o_peak) begin
        o_peak <= mag;
      end
    end
  end

  // Sample RAM: write port for capture, enabled sync read for readout.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= i_data;
    end
    if (rd_en) begin
      ram_q <= mem[rd_cnt[NB_ADDR-1:0]];
    end
  end

  // Read-ahead pipeline: RAM stage feeds output register, stalls on ready.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      rd_cnt     <= '0;
      ram_vld    <= 1'b0;
      ram_last   <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
      o_rd_last  <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= rd_end;
      if (arm_go) begin
        rd_cnt <= '0;
      end else if (rd_en) begin
        rd_cnt <= rd_cnt + CNT_ONE;
      end
      if (rd_en) begin
        ram_vld  <= 1'b1;
        ram_last <= (rd_cnt == LAST_CNT);
      end else if (out_free) begin
        ram_vld  <= 1'b0;
      end
      if (out_free) begin
        o_rd_valid <= ram_vld;
        o_rd_last  <= ram_vld && ram_last;
        if (ram_vld) begin
          o_rd_data <= ram_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_out_capture.sv
// tb_iir_out_capture: randomized record/readout runs checked
// against a queue-based model of the capture buffer.
module tb_iir_out_capture;

  localparam int NB_DATA = 16;
  localparam int DEPTH   = 16;
  localparam int NB_ADDR = 4;

  logic               clock = 1'b0;
  logic               i_reset;
  logic [NB_DATA-1:0] i_data;
  logic               i_enable;
  logic               i_arm;
  logic               i_rd_ready;
  logic [NB_DATA-1:0] o_rd_data;
  logic               o_rd_valid;
  logic               o_rd_last;
  logic               o_busy;
  logic               o_done;
  logic [NB_ADDR:0]   o_count;
  logic [NB_DATA-1:0] o_peak;

  always #5 clock = ~clock;

  iir_out_capture #(
    .NB_DATA(NB_DATA),
    .DEPTH  (DEPTH),
    .NB_ADDR(NB_ADDR)
  ) dut (
    .clock     (clock),
    .i_reset   (i_reset),
    .i_data    (i_data),
    .i_enable  (i_enable),
    .i_arm     (i_arm),
    .i_rd_ready(i_rd_ready),
    .o_rd_data (o_rd_data),
    .o_rd_valid(o_rd_valid),
    .o_rd_last (o_rd_last),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_count   (o_count),
    .o_peak    (o_peak)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] exp_q [$];
  int          exp_peak;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int mag_of(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic logic [15:0] pat(input int mode, input int n);
    case (mode)
      0: return 16'(n);
      1: return 16'($urandom);
      2: case (n % 3)
           0:       return 16'h8000;
           1:       return 16'h7FFE;
           default: return 16'h0001;
         endcase
      default: case (n % 3)
           0:       return 16'hFFFB;
           1:       return 16'h0003;
           default: return 16'hFFFE;
         endcase
    endcase
  endfunction

  task automatic do_reset();
    i_arm = 0; i_enable = 0; i_rd_ready = 0;
    i_reset = 1;
    #1;
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_vld",   32'(o_rd_valid), 0);
    chk("rst_data",  32'(o_rd_data), 0);
    chk("rst_last",  32'(o_rd_last), 0);
    chk("rst_done",  32'(o_done), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_peak",  32'(o_peak), 0);
    step();
    i_reset = 0;
    step();
    chk("rst_nodone", 32'(o_done), 0);
    chk("rst_idle",   32'(o_busy), 0);
  endtask

  task automatic run_record(input int gap, input int rdy,
                            input int dmode, input int abort_cap,
                            input int abort_rd, input bit noise);
    int cyc;
    int k;
    int idx;
    bit en;
    bit rb;
    bit seen;
    bit pv;
    bit pr;
    logic [15:0] d;
    logic [15:0] pd;
    logic pl;
    exp_q.delete();
    exp_peak = 0;
    i_arm = 1; i_enable = 1; i_data = 16'h1234;
    step();
    i_arm = 0;
    chk("arm_busy",  32'(o_busy), 1);
    chk("arm_count", 32'(o_count), 0);
    chk("arm_peak",  32'(o_peak), 0);
    cyc = 0;
    while (exp_q.size() < DEPTH && cyc < 200) begin
      if (abort_cap > 0 && exp_q.size() == abort_cap) begin
        do_reset();
        return;
      end
      case (gap)
        0:       en = 1;
        1:       en = (cyc % 2 == 0);
        default: en = 1'($urandom_range(0, 1));
      endcase
      d = pat(dmode, dmode == 0 ? cyc : exp_q.size());
      i_enable = en;
      i_data = d;
      i_arm = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      cyc++;
      if (en) begin
        exp_q.push_back(d);
        if (mag_of(d) > exp_peak) exp_peak = mag_of(d);
      end
      chk("cap_count", 32'(o_count), 32'(exp_q.size()));
      chk("cap_peak",  32'(o_peak), 32'(exp_peak));
    end
    if (exp_q.size() < DEPTH) chk("cap_timeout", 0, 1);
    i_enable = 0;
    i_arm = 0;
    k = 0; idx = 0; seen = 0; pv = 0; pr = 0; pd = '0; pl = 0;
    while (idx < DEPTH && k < 400) begin
      rb = (rdy == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      i_rd_ready = rb;
      i_arm = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (pv && !pr) begin
        chk("stall_vld",  32'(o_rd_valid), 1);
        chk("stall_data", 32'(o_rd_data), 32'(pd));
        chk("stall_last", 32'(o_rd_last), 32'(pl));
      end
      if (o_rd_valid) begin
        if (!seen) begin
          chk("rd_lat", 32'(k), 2);
          seen = 1;
        end
        chk("rd_data", 32'(o_rd_data), 32'(exp_q[idx]));
        chk("rd_last", 32'(o_rd_last), 32'(idx == DEPTH - 1));
        if (rb) begin
          if (rdy == 0) chk("rd_thru", 32'(k), 32'(idx + 2));
          idx++;
        end
      end
      pv = o_rd_valid; pr = rb; pd = o_rd_data; pl = o_rd_last;
      step();
      k++;
      if (idx < DEPTH) chk("rd_nodone", 32'(o_done), 0);
      if (abort_rd > 0 && idx == abort_rd) begin
        do_reset();
        return;
      end
    end
    if (idx < DEPTH) chk("rd_timeout", 0, 1);
    i_arm = 0;
    chk("end_done",  32'(o_done), 1);
    chk("end_busy",  32'(o_busy), 0);
    chk("end_vld",   32'(o_rd_valid), 0);
    chk("end_count", 32'(o_count), DEPTH);
    chk("end_peak",  32'(o_peak), 32'(exp_peak));
    i_rd_ready = 0;
    step();
    chk("done_pulse", 32'(o_done), 0);
    chk("hold_count", 32'(o_count), DEPTH);
    chk("hold_peak",  32'(o_peak), 32'(exp_peak));
  endtask

  initial begin
    i_reset = 1; i_data = '0; i_enable = 0;
    i_arm = 0; i_rd_ready = 0;
    #12;
    chk("init_busy",  32'(o_busy), 0);
    chk("init_vld",   32'(o_rd_valid), 0);
    chk("init_data",  32'(o_rd_data), 0);
    chk("init_last",  32'(o_rd_last), 0);
    chk("init_done",  32'(o_done), 0);
    chk("init_count", 32'(o_count), 0);
    chk("init_peak",  32'(o_peak), 0);
    i_reset = 0;
    step();
    run_record(0, 0, 0, 0, 0, 0);
    run_record(1, 0, 0, 0, 0, 0);
    run_record(0, 1, 1, 0, 0, 0);
    run_record(0, 0, 2, 0, 0, 0);
    chk("peak_sat", 32'(o_peak), 32'h7FFF);
    run_record(0, 1, 3, 0, 0, 0);
    chk("peak_neg", 32'(o_peak), 5);
    for (int i = 0; i < 4; i++) begin
      i_enable = 1;
      i_data = 16'h7000;
      step();
      chk("idle_count", 32'(o_count), DEPTH);
      chk("idle_peak",  32'(o_peak), 32'(exp_peak));
    end
    i_enable = 0;
    run_record(0, 0, 1, 7, 0, 0);
    run_record(2, 1, 1, 0, 0, 0);
    run_record(0, 1, 1, 0, 4, 0);
    run_record(0, 0, 0, 0, 0, 0);
    run_record(2, 1, 1, 0, 0, 1);
    run_record(0, 0, 1, 0, 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
